logic_flag_unit: RTL and testbench

Parametrised, multi-cycle bitwise logic unit with result flags, for the ALU datapath. Takes two WIDTH-bit operands through a valid/ready handshake and produces a registered result and flags. It processes CHUNK bits per cycle, LSB chunk first, so a narrow datapath can be reused. Beyond per-result flags (zero, all-ones, parity) it keeps a sticky zero flag and a completed-operation counter.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/logic_chunk.sv | 35 +++
 rtl/logic_flag_unit.sv | 153 +++++++++++++++
 tb/tb_logic_flag_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU logic datapath: operation codes and the
// sequencing states of the chunked logic unit.
package alu_pkg;

  localparam logic [2:0] OP_AND     = 3'b000;
  localparam logic [2:0] OP_OR      = 3'b001;
  localparam logic [2:0] OP_XOR     = 3'b010;
  localparam logic [2:0] OP_NOR     = 3'b011;
  localparam logic [2:0] OP_NAND    = 3'b100;
  localparam logic [2:0] OP_XNOR    = 3'b101;
  localparam logic [2:0] OP_PASS_A  = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/logic_chunk.sv
// Combinational bitwise operation on one CHUNK-wide slice, with the slice's
// zero / all-ones / parity contributions for the flag accumulators.
module logic_chunk
  import alu_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [2:0]       op,
  input  logic [CHUNK-1:0] a_chunk,
  input  logic [CHUNK-1:0] b_chunk,
  output logic [CHUNK-1:0] y,
  output logic             is_zero,
  output logic             is_ones,
  output logic             par
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:    y = a_chunk & b_chunk;
      OP_OR:     y = a_chunk | b_chunk;
      OP_XOR:    y = a_chunk ^ b_chunk;
      OP_NOR:    y = ~(a_chunk | b_chunk);
      OP_NAND:   y = ~(a_chunk & b_chunk);
      OP_XNOR:   y = ~(a_chunk ^ b_chunk);
      OP_PASS_A: y = a_chunk;
      default:   y = '0;  // illegal op forces an all-zero slice
    endcase
  end

  assign is_zero = (y == '0);
  assign is_ones = &y;
  assign par     = ^y;

endmodule

// File: rtl/logic_flag_unit.sv
// Multi-cycle bitwise logic unit: operands are latched once, processed
// CHUNK bits per cycle LSB-first, and the result plus flags are held for a
// valid/ready transfer. Tracks a sticky zero flag and a saturating op count.
module logic_flag_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             ones_flag,
  output logic             parity_flag,
  output logic             op_err,
  output logic             sticky_zero,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] op_count
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [IDX_W-1:0] idx;
  logic [31:0]      base;
  logic             zero_acc;
  logic             ones_acc;
  logic             par_acc;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             xfer;

  logic [CHUNK-1:0] y_chunk;
  logic             chunk_zero;
  logic             chunk_ones;
  logic             chunk_par;

  assign base      = 32'(idx) * 32'(CHUNK);
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign xfer      = out_valid_q & out_ready;

  logic_chunk #(.CHUNK(CHUNK)) u_chunk (
    .op      (op_q),
    .a_chunk (a_q[base +: CHUNK]),
    .b_chunk (b_q[base +: CHUNK]),
    .y       (y_chunk),
    .is_zero (chunk_zero),
    .is_ones (chunk_ones),
    .par     (chunk_par)
  );

  // Operand capture: only on acceptance, so later input changes are ignored
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && in_valid) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      idx         <= '0;
      zero_acc    <= 1'b0;
      ones_acc    <= 1'b0;
      par_acc     <= 1'b0;
      result      <= '0;
      zero_flag   <= 1'b0;
      ones_flag   <= 1'b0;
      parity_flag <= 1'b0;
      op_err      <= 1'b0;
      sticky_zero <= 1'b0;
      op_count    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            idx         <= '0;
            zero_acc    <= 1'b1;
            ones_acc    <= 1'b1;
            par_acc     <= 1'b0;
            result      <= '0;
            zero_flag   <= 1'b0;
            ones_flag   <= 1'b0;
            parity_flag <= 1'b0;
            op_err      <= 1'b0;
            in_ready_q  <= 1'b0;
            state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          result[base +: CHUNK] <= y_chunk;
          zero_acc <= zero_acc & chunk_zero;
          ones_acc <= ones_acc & chunk_ones;
          par_acc  <= par_acc ^ chunk_par;
          idx      <= idx + 1'b1;
          // Final slice: fold this cycle's contribution straight into the flags
          if (idx == LAST_IDX) begin
            zero_flag   <= zero_acc & chunk_zero;
            ones_flag   <= ones_acc & chunk_ones;
            parity_flag <= par_acc ^ chunk_par;
            op_err      <= (op_q == OP_ILLEGAL);
            idx         <= '0;
            out_valid_q <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            op_count    <= sat_inc(op_count);
            state       <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= ST_IDLE;
        end
      endcase

      // A zero-result transfer outranks a same-edge clear
      if (xfer && zero_flag)
        sticky_zero <= 1'b1;
      else if (sticky_clr)
        sticky_zero <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_flag_unit.sv
// Randomised and directed bench for logic_flag_unit against a whole-word
// reference model of the bitwise ops, flags, sticky zero and op counter.
module tb_logic_flag_unit;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int CNT_W  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero_flag;
  logic             ones_flag;
  logic             parity_flag;
  logic             op_err;
  logic             sticky_zero;
  logic             sticky_clr;
  logic [CNT_W-1:0] op_count;

  int n_checks = 0;
  int n_fail   = 0;

  int m_count  = 0;
  bit m_sticky = 0;

  always #5 clk = ~clk;

  logic_flag_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero_flag   (zero_flag),
    .ones_flag   (ones_flag),
    .parity_flag (parity_flag),
    .op_err      (op_err),
    .sticky_zero (sticky_zero),
    .sticky_clr  (sticky_clr),
    .op_count    (op_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_result(input logic [2:0] o,
                                                   input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
    case (o)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x | y);
      3'd4: return ~(x & y);
      3'd5: return ~(x ^ y);
      3'd6: return x;
      default: return '0;
    endcase
  endfunction

  task automatic check_idle_outputs();
    check_eq("in_ready", 64'(in_ready), 64'd1);
    check_eq("out_valid", 64'(out_valid), 64'd0);
    check_eq("op_count", 64'(op_count), 64'(m_count));
    check_eq("sticky_zero", 64'(sticky_zero), 64'(m_sticky));
  endtask

  // Full transaction: accept, measure latency, hold under backpressure, transfer
  task automatic run_op(input logic [2:0] o, input logic [WIDTH-1:0] x,
                        input logic [WIDTH-1:0] y, input int hold, input bit clr);
    logic [WIDTH-1:0] er;
    int lat;
    er = ref_result(o, x, y);
    @(negedge clk);
    check_eq("ready_before_accept", 64'(in_ready), 64'd1);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom);
    check_eq("ready_busy", 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat < NCHUNK) begin
        in_valid = 1'b1;  // must be ignored while busy
      end
    end
    in_valid = 1'b0;
    check_eq("latency", 64'(lat), 64'(NCHUNK));
    check_eq("result", 64'(result), 64'(er));
    check_eq("zero_flag", 64'(zero_flag), 64'(er == '0));
    check_eq("ones_flag", 64'(ones_flag), 64'(er == '1));
    check_eq("parity_flag", 64'(parity_flag), 64'(^er));
    check_eq("op_err", 64'(op_err), 64'(o == 3'd7));
    check_eq("ready_done", 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; op = 3'($urandom);
      @(negedge clk);
      check_eq("hold_valid", 64'(out_valid), 64'd1);
      check_eq("hold_ready", 64'(in_ready), 64'd0);
      check_eq("hold_result", 64'(result), 64'(er));
      check_eq("hold_flags", 64'({zero_flag, ones_flag, parity_flag, op_err}),
               64'({er == '0, er == '1, ^er, o == 3'd7}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    sticky_clr = clr;
    @(negedge clk);
    out_ready = 1'b0;
    sticky_clr = 1'b0;
    if (m_count < CMAX) m_count++;
    if (er == '0) m_sticky = 1'b1;
    else if (clr) m_sticky = 1'b0;
    check_idle_outputs();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
    out_ready = 1'b0; sticky_clr = 1'b0;
    #23;
    check_eq("rst_result", 64'(result), 64'd0);
    check_eq("rst_flags", 64'({zero_flag, ones_flag, parity_flag, op_err}), 64'd0);
    check_idle_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(3'd0, 32'hFFFF0000, 32'h00FFFF00, 0, 1'b0);
    run_op(3'd2, 32'h12345678, 32'h12345678, 0, 1'b0);
    @(negedge clk);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    m_sticky = 1'b0;
    check_eq("sticky_clear", 64'(sticky_zero), 64'd0);
    run_op(3'd3, 32'h0, 32'h0, 0, 1'b0);
    run_op(3'd6, 32'h00000001, 32'h0, 0, 1'b0);
    run_op(3'd5, 32'hA5A5A5A5, 32'h0F0F0F0F, 5, 1'b0);
    run_op(3'd7, 32'hFFFFFFFF, 32'h0, 0, 1'b1);
    check_eq("sticky_set_wins", 64'(sticky_zero), 64'd1);

    // Abort in the middle of BUSY
    @(negedge clk);
    in_valid = 1'b1; op = 3'd1; a = 32'h0F0F0F0F; b = 32'hF0F0F0F0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_count = 0; m_sticky = 1'b0;
    check_eq("abort_result", 64'(result), 64'd0);
    check_eq("abort_flags", 64'({zero_flag, ones_flag, parity_flag, op_err}), 64'd0);
    check_idle_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd4, 32'h12345678, 32'hFFFF0000, 1, 1'b0);

    // Random traffic; also drives op_count into saturation
    for (int n = 0; n < 40; n++) begin
      logic [2:0] ro;
      logic [WIDTH-1:0] ra, rb;
      ro = 3'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
      run_op(ro, ra, rb, $urandom_range(0, 3), 1'($urandom));
    end
    check_eq("count_saturated", 64'(op_count), 64'(CMAX));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
